// File: rtl/wb_mux_pkg.sv
// Shared state encodings and sizing helpers for the wishbone master mux.
package wb_mux_pkg;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_WAIT = 2'd1,
        C_DONE = 2'd2
    } ch_state_e;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_BUS  = 1'b1
    } m_state_e;

    // Width of a counter able to reach TIMEOUT; never narrower than one bit.
    function automatic int unsigned to_w(input int unsigned timeout);
        return (timeout < 2) ? 32'd1 : 32'($clog2(timeout + 1));
    endfunction

endpackage

// File: rtl/wb_master_mux_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting after the stored pointer.
module rr_arbiter #(
    parameter int unsigned NCH = 2,
    parameter int unsigned PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] i_req,
    input  logic           i_en,
    input  logic           i_upd,
    input  logic [PW-1:0]  i_upd_idx,
    output logic [NCH-1:0] o_gnt_c,
    output logic [PW-1:0]  o_gnt_idx_c
);

    logic [PW-1:0] r_ptr;

    // Pointer remembers the last served channel; reset value lets channel 0 win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PW'(NCH - 1);
        end else if (i_upd) begin
            r_ptr <= i_upd_idx;
        end
    end

    // Scan channels ptr+1, ptr+2, ... and grant the first requester.
    always_comb begin
        logic found;
        found       = 1'b0;
        o_gnt_c     = '0;
        o_gnt_idx_c = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!found && i_en && i_req[i] && (((32'(r_ptr) + k) % NCH) == i)) begin
                    o_gnt_c[i]  = 1'b1;
                    o_gnt_idx_c = PW'(i);
                    found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_master_mux.sv
// Multi-channel wishbone master front-end with round-robin arbitration,
// error/timeout termination and a per-channel result hold buffer.
module wb_master_mux
    import wb_mux_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned SW      = DW / 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_ce_i,
    input  logic [NCH-1:0]    ch_we_i,
    input  logic [NCH*AW-1:0] ch_addr_i,
    input  logic [NCH*DW-1:0] ch_data_i,
    input  logic [NCH*SW-1:0] ch_sel_i,
    input  logic [NCH-1:0]    ch_hold_i,
    output logic [NCH*DW-1:0] ch_data_o,
    output logic [NCH-1:0]    ch_stallreq_o,
    output logic [NCH-1:0]    ch_err_o,
    input  logic [DW-1:0]     wb_data_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_data_o,
    output logic              wb_we_o,
    output logic [SW-1:0]     wb_sel_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    output logic [NCH-1:0]    wb_grant_o
);

    localparam int unsigned PW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TO_W    = to_w(TIMEOUT);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    ch_state_e         r_ch_state [NCH];
    ch_state_e         w_ch_next  [NCH];
    m_state_e          r_m_state;
    m_state_e          w_m_next;
    logic [NCH-1:0]    w_req;
    logic [NCH-1:0]    w_gnt;
    logic [PW-1:0]     w_gnt_idx;
    logic [PW-1:0]     r_gidx;
    logic [NCH-1:0]    r_grant;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_abort;
    logic              w_gce;
    logic              w_keep;
    logic              w_tmo;
    logic              w_term;
    logic              w_term_err;
    logic [DW-1:0]     w_term_data;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_data;
    logic [SW-1:0]     w_sel_sel;
    logic              w_sel_we;
    logic [AW-1:0]     r_wb_addr;
    logic [DW-1:0]     r_wb_data;
    logic [SW-1:0]     r_wb_sel;
    logic              r_wb_we;
    logic              r_wb_cyc;
    logic [NCH*DW-1:0] r_ch_data;
    logic [NCH-1:0]    r_ch_err;

    // A channel competes for the bus while enabled and not holding a result.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NCH; i++) begin
            w_req[i] = ch_ce_i[i] && (r_ch_state[i] != C_DONE);
        end
    end

    rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
        .clk         (clk),
        .rst_n       (rst),
        .i_req       (w_req),
        .i_en        (r_m_state == M_IDLE),
        .i_upd       (w_term),
        .i_upd_idx   (r_gidx),
        .o_gnt_c     (w_gnt),
        .o_gnt_idx_c (w_gnt_idx)
    );

    // Select the winning channel's request fields.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_sel  = '0;
        w_sel_we   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr = ch_addr_i[i*AW +: AW];
                w_sel_data = ch_data_i[i*DW +: DW];
                w_sel_sel  = ch_sel_i[i*SW +: SW];
                w_sel_we   = ch_we_i[i];
            end
        end
    end

    // Termination: err beats ack; timeout fires only when neither arrives.
    always_comb begin
        w_gce       = |(r_grant & ch_ce_i);
        w_keep      = w_gce && !r_abort;
        w_tmo       = (TIMEOUT != 0) && (r_to_cnt == TO_W'(TO_LAST));
        w_term      = (r_m_state == M_BUS) && (wb_ack_i || wb_err_i || w_tmo);
        w_term_err  = wb_err_i || !wb_ack_i;
        w_term_data = (wb_ack_i && !wb_err_i && !r_wb_we) ? wb_data_i : '0;
    end

    // Master next-state.
    always_comb begin
        w_m_next = r_m_state;
        case (r_m_state)
            M_IDLE:  if (|w_gnt) w_m_next = M_BUS;
            M_BUS:   if (w_term) w_m_next = M_IDLE;
            default: w_m_next = M_IDLE;
        endcase
    end

    // Channel next-state; an aborted owner returns to idle instead of done.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_ch_next[i] = r_ch_state[i];
            case (r_ch_state[i])
                C_IDLE: if (ch_ce_i[i]) w_ch_next[i] = C_WAIT;
                C_WAIT: begin
                    if (w_term && r_grant[i]) w_ch_next[i] = w_keep ? C_DONE : C_IDLE;
                    else if (!ch_ce_i[i])     w_ch_next[i] = C_IDLE;
                end
                C_DONE:  if (!ch_hold_i[i]) w_ch_next[i] = C_IDLE;
                default: w_ch_next[i] = C_IDLE;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_state <= M_IDLE;
            for (int i = 0; i < NCH; i++) r_ch_state[i] <= C_IDLE;
        end else begin
            r_m_state <= w_m_next;
            for (int i = 0; i < NCH; i++) r_ch_state[i] <= w_ch_next[i];
        end
    end

    // Bus outputs: loaded on grant, cleared at termination.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_wb_sel  <= '0;
            r_wb_we   <= 1'b0;
            r_wb_cyc  <= 1'b0;
            r_grant   <= '0;
            r_gidx    <= '0;
        end else if (r_m_state == M_IDLE) begin
            if (|w_gnt) begin
                r_wb_addr <= w_sel_addr;
                r_wb_data <= w_sel_we ? w_sel_data : '0;
                r_wb_sel  <= w_sel_sel;
                r_wb_we   <= w_sel_we;
                r_wb_cyc  <= 1'b1;
                r_grant   <= w_gnt;
                r_gidx    <= w_gnt_idx;
            end
        end else if (w_term) begin
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_wb_sel  <= '0;
            r_wb_we   <= 1'b0;
            r_wb_cyc  <= 1'b0;
            r_grant   <= '0;
        end
    end

    // Wait-state counter and abort flag for the cycle in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
            r_abort  <= 1'b0;
        end else if (r_m_state == M_IDLE) begin
            r_to_cnt <= '0;
            r_abort  <= 1'b0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (!w_gce) r_abort <= 1'b1;
        end
    end

    // Result buffer: captured on entry to done, zero outside done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ch_data <= '0;
            r_ch_err  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (r_ch_state[i] != C_DONE && w_ch_next[i] == C_DONE) begin
                    r_ch_data[i*DW +: DW] <= w_term_data;
                    r_ch_err[i]           <= w_term_err;
                end else if (w_ch_next[i] != C_DONE) begin
                    r_ch_data[i*DW +: DW] <= '0;
                    r_ch_err[i]           <= 1'b0;
                end
            end
        end
    end

    assign wb_addr_o     = r_wb_addr;
    assign wb_data_o     = r_wb_data;
    assign wb_sel_o      = r_wb_sel;
    assign wb_we_o       = r_wb_we;
    assign wb_stb_o      = r_wb_cyc;
    assign wb_cyc_o      = r_wb_cyc;
    assign wb_grant_o    = r_grant;
    assign ch_data_o     = r_ch_data;
    assign ch_err_o      = r_ch_err;
    assign ch_stallreq_o = w_req;

endmodule

// File: tb/tb_wb_master_mux.sv
// Directed bench for wb_master_mux (NCH=2, TIMEOUT=4).
module tb_wb_master_mux;

    localparam int unsigned NCH = 2;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_ce_i;
    logic [NCH-1:0]    ch_we_i;
    logic [NCH*AW-1:0] ch_addr_i;
    logic [NCH*DW-1:0] ch_data_i;
    logic [NCH*SW-1:0] ch_sel_i;
    logic [NCH-1:0]    ch_hold_i;
    logic [NCH*DW-1:0] ch_data_o;
    logic [NCH-1:0]    ch_stallreq_o;
    logic [NCH-1:0]    ch_err_o;
    logic [DW-1:0]     wb_data_i;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic [AW-1:0]     wb_addr_o;
    logic [DW-1:0]     wb_data_o;
    logic              wb_we_o;
    logic [SW-1:0]     wb_sel_o;
    logic              wb_stb_o;
    logic              wb_cyc_o;
    logic [NCH-1:0]    wb_grant_o;

    logic              auto_ack;
    logic              auto_err;
    logic [DW-1:0]     rdata;
    int                n_total;
    int                n_bad;
    logic [1:0]        g_tab [0:6];

    always #5 clk = ~clk;

    // Trivial slave: responds in the first stb cycle when enabled.
    assign wb_ack_i  = auto_ack & wb_stb_o;
    assign wb_err_i  = auto_err & wb_stb_o;
    assign wb_data_i = rdata;

    wb_master_mux #(
        .NCH(NCH), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ch_ce_i       (ch_ce_i),
        .ch_we_i       (ch_we_i),
        .ch_addr_i     (ch_addr_i),
        .ch_data_i     (ch_data_i),
        .ch_sel_i      (ch_sel_i),
        .ch_hold_i     (ch_hold_i),
        .ch_data_o     (ch_data_o),
        .ch_stallreq_o (ch_stallreq_o),
        .ch_err_o      (ch_err_o),
        .wb_data_i     (wb_data_i),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i),
        .wb_addr_o     (wb_addr_o),
        .wb_data_o     (wb_data_o),
        .wb_we_o       (wb_we_o),
        .wb_sel_o      (wb_sel_o),
        .wb_stb_o      (wb_stb_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_grant_o    (wb_grant_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Start of a cycle: just after the rising edge, where inputs change.
    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    // Middle of a cycle: outputs are sampled on the falling edge.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b0;
        ch_ce_i   = '0;
        ch_we_i   = '0;
        ch_addr_i = '0;
        ch_data_i = '0;
        ch_sel_i  = '0;
        ch_hold_i = '0;
        auto_ack  = 1'b0;
        auto_err  = 1'b0;
        rdata     = '0;
        g_tab[0] = 2'b01; g_tab[1] = 2'b00; g_tab[2] = 2'b10; g_tab[3] = 2'b00;
        g_tab[4] = 2'b01; g_tab[5] = 2'b00; g_tab[6] = 2'b10;

        #3;
        check("rst_cyc",   64'(wb_cyc_o),   64'd0);
        check("rst_grant", 64'(wb_grant_o), 64'd0);
        check("rst_data",  64'(ch_data_o),  64'd0);
        check("rst_err",   64'(ch_err_o),   64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single read, zero-wait ack.
        cyc_start();
        ch_addr_i[31:0] = 32'h100;
        ch_data_i[31:0] = 32'hAAAA5555;
        ch_sel_i[3:0]   = 4'hF;
        ch_ce_i         = 2'b01;
        auto_ack        = 1'b1;
        rdata           = 32'hDEADBEEF;
        mid();
        check("t1_stall_c0", 64'(ch_stallreq_o), 64'b01);
        check("t1_stb_c0",   64'(wb_stb_o),      64'd0);
        cyc_start();
        mid();
        check("t1_stb_c1",   64'(wb_stb_o),   64'd1);
        check("t1_addr_c1",  64'(wb_addr_o),  64'h100);
        check("t1_grant_c1", 64'(wb_grant_o), 64'b01);
        check("t1_wdat_c1",  64'(wb_data_o),  64'd0);
        cyc_start();
        mid();
        check("t1_data_c2",  64'(ch_data_o[31:0]), 64'hDEADBEEF);
        check("t1_stall_c2", 64'(ch_stallreq_o),   64'd0);
        check("t1_err_c2",   64'(ch_err_o),        64'd0);
        check("t1_cyc_c2",   64'(wb_cyc_o),        64'd0);
        cyc_start();
        ch_ce_i = 2'b00;
        mid();
        check("t1_data_c3", 64'(ch_data_o), 64'd0);

        // Both channels from reset: alternating grants with idle gaps.
        do_reset();
        ch_addr_i = {32'h20, 32'h10};
        ch_we_i   = 2'b00;
        ch_ce_i   = 2'b11;
        rdata     = 32'h0BADF00D;
        mid();
        for (int c = 0; c < 7; c++) begin
            cyc_start();
            mid();
            check("t2_grant", 64'(wb_grant_o), 64'(g_tab[c]));
            if (c == 2) check("t2_addr_ch1", 64'(wb_addr_o), 64'h20);
            if (c == 3) check("t2_data_ch1", 64'(ch_data_o[63:32]), 64'h0BADF00D);
        end
        cyc_start();
        ch_ce_i = 2'b00;
        cyc_start();

        // Channel 1 write.
        cyc_start();
        ch_addr_i[63:32] = 32'h2000;
        ch_data_i[63:32] = 32'h12345678;
        ch_sel_i[7:4]    = 4'b0011;
        ch_we_i          = 2'b10;
        ch_ce_i          = 2'b10;
        rdata            = 32'hCAFEF00D;
        cyc_start();
        mid();
        check("t3_we",    64'(wb_we_o),    64'd1);
        check("t3_sel",   64'(wb_sel_o),   64'b0011);
        check("t3_wdat",  64'(wb_data_o),  64'h12345678);
        check("t3_addr",  64'(wb_addr_o),  64'h2000);
        check("t3_grant", 64'(wb_grant_o), 64'b10);
        cyc_start();
        mid();
        check("t3_rdat",  64'(ch_data_o[63:32]), 64'd0);
        check("t3_err",   64'(ch_err_o),         64'd0);
        check("t3_stall", 64'(ch_stallreq_o),    64'd0);
        cyc_start();
        ch_ce_i = 2'b00;
        ch_we_i = 2'b00;
        cyc_start();

        // ack and err together, result held for three cycles.
        cyc_start();
        ch_addr_i[31:0] = 32'h300;
        ch_ce_i         = 2'b01;
        ch_hold_i       = 2'b01;
        auto_err        = 1'b1;
        rdata           = 32'h11111111;
        cyc_start();
        cyc_start();
        mid();
        check("t4_err_c2",  64'(ch_err_o),         64'b01);
        check("t4_data_c2", 64'(ch_data_o[31:0]),  64'd0);
        cyc_start();
        mid();
        check("t4_err_c3",  64'(ch_err_o),         64'b01);
        cyc_start();
        mid();
        check("t4_err_c4",   64'(ch_err_o),      64'b01);
        check("t4_stall_c4", 64'(ch_stallreq_o), 64'd0);
        check("t4_cyc_c4",   64'(wb_cyc_o),      64'd0);
        cyc_start();
        ch_hold_i = 2'b00;
        ch_ce_i   = 2'b00;
        mid();
        check("t4_err_c5", 64'(ch_err_o), 64'b01);
        cyc_start();
        mid();
        check("t4_err_c6", 64'(ch_err_o), 64'd0);
        auto_err = 1'b0;
        auto_ack = 1'b0;

        // Silent slave: timeout after four stb cycles.
        cyc_start();
        ch_addr_i[31:0] = 32'h400;
        ch_ce_i         = 2'b01;
        for (int c = 1; c <= 4; c++) begin
            cyc_start();
            mid();
            check("t5_cyc_wait", 64'(wb_cyc_o), 64'd1);
        end
        cyc_start();
        ch_ce_i = 2'b00;
        mid();
        check("t5_cyc_end", 64'(wb_cyc_o),        64'd0);
        check("t5_err",     64'(ch_err_o),        64'b01);
        check("t5_data",    64'(ch_data_o[31:0]), 64'd0);
        cyc_start();

        // Asynchronous reset during a bus cycle.
        cyc_start();
        ch_addr_i[31:0] = 32'h500;
        ch_ce_i         = 2'b01;
        cyc_start();
        mid();
        check("t6_stb_pre", 64'(wb_stb_o), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t6_cyc_rst",   64'(wb_cyc_o),   64'd0);
        check("t6_stb_rst",   64'(wb_stb_o),   64'd0);
        check("t6_grant_rst", 64'(wb_grant_o), 64'd0);
        check("t6_data_rst",  64'(ch_data_o),  64'd0);
        cyc_start();
        rst      = 1'b1;
        ch_ce_i  = 2'b11;
        auto_ack = 1'b1;
        cyc_start();
        mid();
        check("t6_first_grant", 64'(wb_grant_o), 64'b01);
        cyc_start();
        ch_ce_i = 2'b00;
        cyc_start();
        cyc_start();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_master_mux.md
Name: wb_master_mux

Overview:
- Parametrised wishbone master front-end shared by NCH CPU-side request channels. Typical channels are instruction fetch and data load/store.
- Supersedes one single-channel bus interface per port. Adds round-robin arbitration onto one wishbone master, bus-error and timeout termination, and a per-channel result hold buffer.
- Sits between the pipeline (IF/ME stall requests into Ctrl) and the system wishbone interconnect.

Parameters:
- NCH, 2, number of request channels (>=1).
- AW, 32, address width.
- DW, 32, data width.
- SW, DW/8, byte-select width.
- TIMEOUT, 255, max cycles waiting for ack/err after stb; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ch_ce_i  in  NCH  per-channel request enable.
- ch_we_i  in  NCH  per-channel write enable.
- ch_addr_i  in  NCH*AW  per-channel address; channel i occupies [i*AW +: AW].
- ch_data_i  in  NCH*DW  per-channel write data.
- ch_sel_i  in  NCH*SW  per-channel byte selects.
- ch_hold_i  in  NCH  pipeline stalled for this channel; keep the result buffered.
- ch_data_o  out  NCH*DW  per-channel read result.
- ch_stallreq_o  out  NCH  stall request to Ctrl.
- ch_err_o  out  NCH  result terminated by bus error or timeout.
- wb_data_i  in  DW  slave read data.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.
- wb_addr_o  out  AW  master address.
- wb_data_o  out  DW  master write data.
- wb_we_o  out  1  master write enable.
- wb_sel_o  out  SW  master byte select.
- wb_stb_o  out  1  master strobe.
- wb_cyc_o  out  1  master cycle.
- wb_grant_o  out  NCH  one-hot owner of the current bus cycle; debug only.

Behaviour:

Reset:
- All wb_* outputs, ch_data_o, ch_err_o and wb_grant_o are 0.
- Every channel is in C_IDLE; master is in M_IDLE.
- Round-robin pointer is NCH-1, so channel 0 wins first.
- Reset is asynchronous. Asserting it mid-cycle drops cyc/stb immediately and discards the transfer in flight.

Channel FSM (per channel): C_IDLE, C_WAIT, C_DONE.
- C_IDLE -> C_WAIT when ce_i=1.
- C_WAIT -> C_DONE on termination of its granted bus cycle.
- C_WAIT -> C_IDLE if ce_i drops before grant.
- C_DONE: ch_data_o holds the buffered result. Exit to C_IDLE on the first cycle with hold_i=0.
- ch_data_o is 0 in C_IDLE and C_WAIT.
- ch_stallreq_o = ce_i AND (state != C_DONE). This is combinational, so it asserts in the same cycle ce_i rises.

Master FSM: M_IDLE, M_BUS.
- M_IDLE: arbitrate among channels in C_WAIT, or in C_IDLE with ce_i=1. Round-robin starts at the pointer+1.
- On grant, register that channel's addr/data/we/sel onto wb_*. Set cyc=stb=1 and enter M_BUS. The bus cycle starts the cycle after ce_i rises at the earliest.
- Write data is driven only when we=1; otherwise wb_data_o=0.
- wb_* outputs are 0 whenever in M_IDLE.

M_BUS termination, evaluated each cycle:
- err_i=1: result data 0, ch_err_o=1. err takes priority if ack and err are both high.
- ack_i=1: result = wb_data_i for reads, 0 for writes; ch_err_o=0.
- Timeout counter (cleared on entering M_BUS) reaching TIMEOUT with no ack/err: data 0, ch_err_o=1.
- On termination:
  - cyc/stb drop at that edge and the master returns to M_IDLE.
  - The granted channel enters C_DONE.
  - The pointer is set to the granted channel.
- Re-arbitration happens in M_IDLE the following cycle, giving one idle bus cycle between transfers.

Abort:
- If a granted channel drops ce_i during M_BUS, the bus cycle still completes.
- Its result is discarded; the channel goes to C_IDLE, not C_DONE.

Latency:
- With an ack in the first stb cycle: ce_i at cycle 0, stb at cycle 1, data_o valid and stallreq low at cycle 2.
- In general: cycles = 1 + wait states + 1.

Other rules:
- ch_err_o is valid only in C_DONE and clears when the channel leaves C_DONE.
- A new request from a channel sitting in C_DONE is not issued until hold_i=0.

Decomposition:
- Package wb_mux_pkg holds the channel and master state encodings and TO_W = clog2(TIMEOUT+1) as a helper function.
- Sub-module rr_arbiter (parameter NCH) takes req[NCH], ptr and an enable. It produces a one-hot grant and a registered pointer update.

Test Plan:
1. NCH=2, ch0 read addr 0x100, slave acks in the first stb cycle with 0xDEADBEEF -> stb high at cycle 1; ch0 data_o=0xDEADBEEF and stallreq=0 at cycle 2.
2. ch0 and ch1 both request from reset, repeatedly, with zero-wait acks -> grant order 0,1,0,1; one idle bus cycle between transfers.
3. ch1 write, addr 0x2000, data 0x12345678, sel 4'b0011 -> wb_we=1, sel=0011, data_o=0x12345678; ch1 data_o=0 after ack.
4. ch0 read with wb_ack_i and wb_err_i high together -> ch0 err_o=1 and data_o=0; with hold_i=1 for 3 cycles, err/data persist, then clear one cycle after hold_i falls.
5. TIMEOUT=4, slave never responds -> cyc drops after 4 stb cycles; err_o=1.
6. Assert rst low during M_BUS -> cyc/stb drop without a clock edge; all outputs 0; the first request after release goes to ch0.
